// File: rtl/johnson_pkg.sv
// johnson_pkg
//   Shared definitions for the Johnson-ring step sequencer:
//   - state_t       : controller FSM states
//   - RING_W/CNT_DW/PH_DW : default ring, step-count and phase widths
//   - RESET_PATTERN : ring value after reset (phase 2*RING_W-1)
//   - phase_of()    : twisted-ring state -> phase index decode
package johnson_pkg;

   localparam int RING_W = 5;
   localparam int CNT_DW = 8;
   localparam int PH_DW  = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [RING_W-1:0] RESET_PATTERN = 5'b10000;

   // Legal Johnson states fill with ones from the LSB, then drain from the
   // LSB. While the MSB is clear the ones count is the phase; once the MSB
   // is set the ring is on its second half, so the phase is 2*w - ones.
   // qv is zero-extended; only the low w bits take part.
   function automatic logic [7:0] phase_of(input logic [31:0] qv, input int w);
      int ones;
      ones = 0;
      for (int i = 0; i < 32; i++) begin
         if (i < w && qv[i]) ones++;
      end
      if (qv[w-1]) return 8'(2*w - ones);
      else         return 8'(ones);
   endfunction

endpackage

// File: rtl/johnson_ring.sv
// johnson_ring
//   Left-shifting twisted-ring (Johnson) counter datapath. Advances by one
//   state on a rising clk edge when adv is high, otherwise holds.
// Ports:
//   clk  in   rising-edge clock
//   rst  in   asynchronous active-high reset, loads the reset pattern
//   adv  in   advance enable for this edge
//   q    out  ring state
module johnson_ring
   import johnson_pkg::*;
#(
   parameter int WIDTH = RING_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             adv,
   output logic [WIDTH-1:0] q
);

   // Both arms give MSB-only-set; the first keeps the shared constant as
   // the source of truth at the default width.
   localparam logic [WIDTH-1:0] RST_Q = (WIDTH == RING_W) ? WIDTH'(RESET_PATTERN)
                                                          : {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (adv) q_d = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) q_q <= RST_Q;
      else     q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/johnson_seq_ctrl.sv
// johnson_seq_ctrl
//   Step-count sequencer for the Johnson ring. A start in IDLE latches a
//   step count; the ring then advances once per clock until the count is
//   exhausted, freezing while pause is high and abandoning the run on stop.
// Ports:
//   clk, rst      clock (rising) / async active-high reset
//   start, steps  run request and step count, sampled together in IDLE
//   pause         level; freezes the ring during a run
//   stop          abort; beats pause and advance
//   q             ring state
//   phase         decoded phase index 0..2*WIDTH-1 (combinational from q)
//   phase_oh      one-hot of phase (combinational from q)
//   busy, paused  high in RUN/HOLD and HOLD respectively
//   done, aborted one-cycle pulses for normal / stop-terminated completion
//   wrap          one-cycle pulse after the ring steps from the last phase to 0
module johnson_seq_ctrl
   import johnson_pkg::*;
#(
   parameter int WIDTH = RING_W,
   parameter int CNT_W = CNT_DW,
   parameter int PH_W  = PH_DW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [CNT_W-1:0]     steps,
   input  logic                 pause,
   input  logic                 stop,
   output logic [WIDTH-1:0]     q,
   output logic [PH_W-1:0]      phase,
   output logic [2*WIDTH-1:0]   phase_oh,
   output logic                 busy,
   output logic                 paused,
   output logic                 done,
   output logic                 aborted,
   output logic                 wrap
);

   localparam int NPH = 2 * WIDTH;

   state_t           state_q,   state_d;
   logic [CNT_W-1:0] rem_q,     rem_d;
   logic             busy_q,    busy_d;
   logic             paused_q,  paused_d;
   logic             done_q,    done_d;
   logic             aborted_q, aborted_d;
   logic             wrap_q,    wrap_d;
   logic             adv;

   johnson_ring #(.WIDTH(WIDTH)) u_ring (
      .clk (clk),
      .rst (rst),
      .adv (adv),
      .q   (q)
   );

   assign phase    = PH_W'(phase_of(32'(q), WIDTH));
   assign phase_oh = NPH'(1) << phase;

   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      adv       = 1'b0;
      aborted_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!stop && start) begin
               if (steps == '0) begin
                  state_d = ST_DONE;
               end else begin
                  rem_d   = steps;
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (stop) begin
               state_d   = ST_IDLE;
               rem_d     = '0;
               aborted_d = 1'b1;
            end else if (pause) begin
               state_d = ST_HOLD;
            end else begin
               // rem_q >= 1 in RUN, so the decrement cannot underflow
               adv   = 1'b1;
               rem_d = rem_q - CNT_W'(1);
               if (rem_q == CNT_W'(1)) state_d = ST_DONE;
            end
         end
         ST_HOLD: begin
            if (stop) begin
               state_d   = ST_IDLE;
               rem_d     = '0;
               aborted_d = 1'b1;
            end else if (!pause) begin
               // back to RUN only; the next advance waits for the next edge
               state_d = ST_RUN;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Status outputs are registered copies of the next state so they line
      // up with state_q and clear asynchronously with reset.
      busy_d   = (state_d == ST_RUN) || (state_d == ST_HOLD);
      paused_d = (state_d == ST_HOLD);
      done_d   = (state_d == ST_DONE);
      wrap_d   = adv && (phase == PH_W'(NPH - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         rem_q     <= '0;
         busy_q    <= 1'b0;
         paused_q  <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         busy_q    <= busy_d;
         paused_q  <= paused_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
         wrap_q    <= wrap_d;
      end
   end

   assign busy    = busy_q;
   assign paused  = paused_q;
   assign done    = done_q;
   assign aborted = aborted_q;
   assign wrap    = wrap_q;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// tb_johnson_seq_ctrl
//   Scenario bench for johnson_seq_ctrl. The reference tracks the ring as a
//   phase number (advance = +1 mod 2*W) and rebuilds the expected ring
//   pattern and one-hot from that number.
module tb_johnson_seq_ctrl;

   localparam int W  = 5;
   localparam int CW = 8;
   localparam int PW = 4;
   localparam int NP = 2 * W;
   localparam int OW = W + PW + NP + 5;

   logic          clk = 1'b0;
   logic          rst, start, pause, stop;
   logic [CW-1:0] steps;
   logic [W-1:0]  q;
   logic [PW-1:0] phase;
   logic [NP-1:0] phase_oh;
   logic          busy, paused, done, aborted, wrap;

   int checks = 0;
   int errors = 0;
   int mph    = NP - 1;

   logic [OW-1:0] obs;
   logic [OW-1:0] e;

   always #5 clk = ~clk;

   johnson_seq_ctrl #(.WIDTH(W), .CNT_W(CW), .PH_W(PW)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .steps    (steps),
      .pause    (pause),
      .stop     (stop),
      .q        (q),
      .phase    (phase),
      .phase_oh (phase_oh),
      .busy     (busy),
      .paused   (paused),
      .done     (done),
      .aborted  (aborted),
      .wrap     (wrap)
   );

   assign obs = {q, phase, phase_oh, busy, paused, done, aborted, wrap};

   // Ring pattern for phase p: p ones from the LSB in the first half, then
   // an all-ones word shifted left by (p - W) in the second half.
   function automatic logic [W-1:0] pat(int p);
      int v;
      if (p < W) v = (1 << p) - 1;
      else       v = (((1 << W) - 1) << (p - W)) & ((1 << W) - 1);
      return W'(v);
   endfunction

   function automatic logic [OW-1:0] expv(int p, bit b, bit pa, bit d, bit a, bit w);
      logic [NP-1:0] oh;
      oh = NP'(1) << p;
      return {pat(p), PW'(p), oh, b, pa, d, a, w};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mph = NP - 1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0; steps = '0;
      #2;
      mph = NP - 1;
      e = expv(mph, 0, 0, 0, 0, 0);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL reset_async: got %h expected %h", obs, e); end
      tick(); tick();
      rst = 1'b0;
      tick();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL reset_release: got %h expected %h", obs, e); end
   endtask

   // Plain run of n>=1 steps; with noise, start/steps toggle randomly while
   // busy and must have no effect.
   task automatic test_run(int n, string nm, bit noise);
      steps = CW'(n); start = 1'b1;
      tick();
      start = 1'b0;
      e = expv(mph, 1, 0, 0, 0, 0);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL %s_accept: got %h expected %h", nm, obs, e); end
      for (int k = 1; k <= n; k++) begin
         if (noise) begin start = 1'($urandom); steps = CW'($urandom); end
         tick();
         mph = (mph + 1) % NP;
         e = expv(mph, k != n, 0, k == n, 0, mph == 0);
         checks++;
         if (obs !== e) begin errors++; $display("FAIL %s_step%0d: got %h expected %h", nm, k, obs, e); end
      end
      start = 1'b0;
      tick();
      e = expv(mph, 0, 0, 0, 0, 0);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL %s_idle: got %h expected %h", nm, obs, e); end
   endtask

   task automatic test_pause();
      do_reset();
      steps = CW'(6); start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 2; k++) begin
         tick();
         mph = (mph + 1) % NP;
         e = expv(mph, 1, 0, 0, 0, mph == 0);
         checks++;
         if (obs !== e) begin errors++; $display("FAIL pause_pre%0d: got %h expected %h", k, obs, e); end
      end
      pause = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         e = expv(mph, 1, 1, 0, 0, 0);
         checks++;
         if (obs !== e) begin errors++; $display("FAIL pause_hold%0d: got %h expected %h", k, obs, e); end
      end
      pause = 1'b0;
      tick();
      e = expv(mph, 1, 0, 0, 0, 0);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL pause_resume: got %h expected %h", obs, e); end
      for (int k = 3; k <= 6; k++) begin
         tick();
         mph = (mph + 1) % NP;
         e = expv(mph, k != 6, 0, k == 6, 0, mph == 0);
         checks++;
         if (obs !== e) begin errors++; $display("FAIL pause_post%0d: got %h expected %h", k, obs, e); end
      end
      tick();
   endtask

   task automatic test_stop();
      do_reset();
      steps = CW'(8); start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         mph = (mph + 1) % NP;
      end
      stop = 1'b1;
      tick();
      e = expv(mph, 0, 0, 0, 1, 0);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL stop_run_abort: got %h expected %h", obs, e); end
      stop = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         e = expv(mph, 0, 0, 0, 0, 0);
         checks++;
         if (obs !== e) begin errors++; $display("FAIL stop_run_after%0d: got %h expected %h", k, obs, e); end
      end
      // abort from HOLD
      steps = CW'(5); start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      mph = (mph + 1) % NP;
      pause = 1'b1;
      tick();
      e = expv(mph, 1, 1, 0, 0, 0);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL stop_hold_enter: got %h expected %h", obs, e); end
      stop = 1'b1;
      tick();
      pause = 1'b0; stop = 1'b0;
      e = expv(mph, 0, 0, 0, 1, 0);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL stop_hold_abort: got %h expected %h", obs, e); end
      tick();
      e = expv(mph, 0, 0, 0, 0, 0);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL stop_hold_after: got %h expected %h", obs, e); end
   endtask

   task automatic test_zero_and_collide();
      steps = '0; start = 1'b1;
      tick();
      start = 1'b0;
      e = expv(mph, 0, 0, 1, 0, 0);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL zero_done: got %h expected %h", obs, e); end
      tick();
      e = expv(mph, 0, 0, 0, 0, 0);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL zero_after: got %h expected %h", obs, e); end
      start = 1'b1; stop = 1'b1; steps = CW'($urandom_range(1, 255));
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL collide%0d: got %h expected %h", k, obs, e); end
      end
      start = 1'b0; stop = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      steps = CW'(7); start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      #2;
      rst = 1'b1;
      #1;
      mph = NP - 1;
      e = expv(mph, 0, 0, 0, 0, 0);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL midrst_async: got %h expected %h", obs, e); end
      tick();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL midrst_quiet%0d: got %h expected %h", k, obs, e); end
      end
      test_run(1, "midrst_run1", 0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++) begin
         int gap;
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            tick();
            e = expv(mph, 0, 0, 0, 0, 0);
            checks++;
            if (obs !== e) begin errors++; $display("FAIL rand%0d_gap: got %h expected %h", i, obs, e); end
         end
         test_run(int'($urandom_range(1, 25)), $sformatf("rand%0d", i), 1);
      end
      test_run(255, "max_steps", 0);
   endtask

   initial begin
      test_reset();
      test_run(3, "steps3", 0);
      do_reset();
      test_run(10, "steps10", 0);
      test_pause();
      test_stop();
      test_zero_and_collide();
      test_reset_mid_run();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
